poly_sample_generator: RTL and testbench
========================================

// Module: poly_sample_generator
// PURPOSE
//   Polyphonic DDS sample generator, successor to the single-voice synth sampler.
//   VOICES independent phase accumulators, each with its own MIDI note, gate and waveform.
//   Voices are processed time-multiplexed, one per clock, and mixed into one signed sample per strobe.
//   Feeds the DAC/I2S serialiser through outSample/outSampleReady.
// PARAMETERS
//   VOICES  4   voice count; power of 2, 1..16
//   N       24  phase accumulator width; must equal the tableFrequencyStep output width
//   M       12  output sample width, signed; M>=12; 12-bit waveforms are left-justified into M bits
// PORTS
//   inCLK_50MHZ      in   1          system clock, sole clock
//   inRST_N          in   1          asynchronous active-low reset
//   inSAMPLE_CLK     in   1          sample-rate strobe (level), synchronous to inCLK_50MHZ
//   inVoiceGate      in   VOICES     per-voice note on; bit v = voice v
//   inVoiceWaveMode  in   2*VOICES   per-voice mode, [2v+1:2v]: 0 sine, 1 square, 2 saw, 3 triangle
//   inVoiceNote      in   7*VOICES   per-voice MIDI frequency index, [7v+6:7v]
//   outSample        out  M          signed mixed sample, held until next frame
//   outSampleReady   out  1          one-cycle pulse: outSample updated
//   outBusy          out  1          high while a frame is being computed
//   outClip          out  1          one-cycle pulse with outSampleReady when mix saturated
// BEHAVIOUR
//   Reset (async, inRST_N=0): all phases=0, FSM=IDLE, outSample=0, outSampleReady=0, outBusy=0, outClip=0, edge reg=0.
//   Strobe: edge = inSAMPLE_CLK & ~prev; prev is a register. Level-high periods alone never retrigger.
//   FSM IDLE->RUN on edge (clock t0). In RUN, voice idx v=0..VOICES-1 on clocks t0+1..t0+VOICES.
//   In RUN, RUN->DRAIN after the last voice; DRAIN->DONE; DONE->IDLE.
//   Stage 1 (voice v): read voice v inputs at this clock.
//     If gate=1: phase[v] += step(note[v]), mod 2^N.
//     If gate=0: phase[v] <= 0, so the next note-on starts at phase 0.
//   Stage 2 (next clock): shape the updated phase into a 12-bit signed wave w. Gated-off voice gives w=0.
//     Accumulate w into a signed sum of M+log2(VOICES) bits. The sum is cleared at t0.
//   Waveforms (p = phase[v]):
//     sine     = tableSinewave[p[N-1:N-10]]
//     square   = p[N-1] ? 12'h801 : 12'h7ff
//     saw      = {~p[N-1], p[N-2:N-12]}
//     triangle = {~t[11], t[10:0]}, where t = p[N-1] ? ~p[N-2:N-13] : p[N-2:N-13]
//   DONE clock: outSample, outClip and outSampleReady are registered together.
//     outSampleReady is high exactly the cycle after clock t0+VOICES+2, i.e. latency VOICES+2 clocks.
//   outBusy is 1 from the clock after t0 until outSampleReady is asserted.
//   An edge while outBusy=1 is ignored. It is not queued and the frame is not restarted.
//   Voice inputs changing mid-frame take effect for any voice not yet read; no input latching.
//   Minimum strobe period: VOICES+4 clocks.
//   Reset asserted mid-frame aborts the frame. No outSampleReady is produced for it.
// CONFIGURATION
//   POLY_SAMPLE_GEN_SATURATE_EN defined:
//     outSample = sum clamped to [-2^(M-1), 2^(M-1)-1]; full per-voice amplitude.
//     outClip pulses when the clamp is active.
//   Not defined:
//     outSample = sum >>> log2(VOICES) (arithmetic); cannot overflow; outClip is tied 0.
// STRUCTURE
//   Package poly_synth_pkg holds:
//     wave mode constants WAVE_SINE/SQUARE/SAW/TRI
//     square level constants 12'h801/12'h7ff
//     FSM state encoding IDLE/RUN/DRAIN/DONE
//     log2 helper function
//   Sub-module poly_voice_shaper: combinational phase+mode -> 12-bit wave; contains the tableSinewave instance.
//   One shared tableFrequencyStep instance, muxed by voice index. Phases held in a VOICES x N register array.
// TESTING
//   Reset: hold inRST_N=0, toggle strobe.
//     -> outSample=0, outSampleReady never 1, outBusy=0.
//   Latency: VOICES=4, one edge.
//     -> outSampleReady is a single pulse 6 clocks after the edge clock; outBusy high in between.
//   Single voice square:
//     gate=4'b0001, mode 1, all other gates 0, no SATURATE_EN.
//     -> first sample 12'h7ff>>>2 = 12'h1ff.
//     -> sign flips after 2^(N-1)/step frames.
//   Saturation, SATURATE_EN defined: 4 voices, square, same note, gates on.
//     -> outSample = 12'h7ff, outClip=1 on the first frame.
//     -> outSample = 12'h800, outClip=1 once the phases pass half-period.
//   Gate retrigger: voice 0 gate on for 100 frames, off 1 frame, then on.
//     -> first frame after re-on has phase[0] = step exactly (restarted from 0).
//   Overrun: second strobe edge 3 clocks after the first.
//     -> ignored; exactly one outSampleReady; result matches the single-edge run.

Source files
------------

// File: rtl/poly_synth_pkg.sv
// Shared constants, state encoding and helpers for the polyphonic sample generator.
package poly_synth_pkg;

   localparam logic [1:0] WAVE_SINE   = 2'd0;
   localparam logic [1:0] WAVE_SQUARE = 2'd1;
   localparam logic [1:0] WAVE_SAW    = 2'd2;
   localparam logic [1:0] WAVE_TRI    = 2'd3;

   localparam logic [11:0] SQUARE_LOW  = 12'h801;
   localparam logic [11:0] SQUARE_HIGH = 12'h7ff;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } fsmState_e;

   // Smallest r with 2**r >= value.
   function automatic int log2Ceil(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << r) < value) begin
            r = r + 1;
         end else begin
            r = r;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/poly_voice_shaper.sv
// Combinational phase + mode -> 12-bit signed wave for one voice; owns the sine table.
module poly_voice_shaper
   import poly_synth_pkg::*;
(
   input  logic [12:0] inPhaseTop,
   input  logic [1:0]  inMode,
   input  logic        inGate,
   output logic [11:0] outWave
);

   logic [11:0] sine_s;
   logic [11:0] tri_s;

   tableSinewave sineTable (
      .inAddr    (inPhaseTop[12:3]),
      .outSample (sine_s)
   );

   // Select waveform; a gated-off voice contributes silence.
   always_comb begin
      if (inPhaseTop[12]) begin
         tri_s = ~inPhaseTop[11:0];
      end else begin
         tri_s = inPhaseTop[11:0];
      end
      case (inMode)
         WAVE_SINE:   outWave = sine_s;
         WAVE_SQUARE: outWave = inPhaseTop[12] ? SQUARE_LOW : SQUARE_HIGH;
         WAVE_SAW:    outWave = {~inPhaseTop[12], inPhaseTop[11:1]};
         WAVE_TRI:    outWave = {~tri_s[11], tri_s[10:0]};
         default:     outWave = 12'h000;
      endcase
      if (!inGate) begin
         outWave = 12'h000;
      end else begin
         outWave = outWave;
      end
   end

endmodule

// File: rtl/tableFrequencyStep.sv
// MIDI note -> 24-bit phase step for a 48 kHz sample strobe.
// The top octave (notes 120..131) is tabulated; lower octaves are right shifts of it.
module tableFrequencyStep (
   input  logic [6:0]  inNote,
   output logic [23:0] outStep
);

   logic [6:0]  octave_s;
   logic [6:0]  semi_s;
   logic [23:0] base_s;

   // Split note into octave and semitone, then scale the top-octave step down.
   always_comb begin
      octave_s = inNote / 7'd12;
      semi_s   = inNote % 7'd12;
      case (semi_s)
         7'd0:    base_s = 24'd2926232;
         7'd1:    base_s = 24'd3100235;
         7'd2:    base_s = 24'd3284584;
         7'd3:    base_s = 24'd3479896;
         7'd4:    base_s = 24'd3686822;
         7'd5:    base_s = 24'd3906049;
         7'd6:    base_s = 24'd4138315;
         7'd7:    base_s = 24'd4384392;
         7'd8:    base_s = 24'd4645103;
         7'd9:    base_s = 24'd4921317;
         7'd10:   base_s = 24'd5213951;
         7'd11:   base_s = 24'd5523990;
         default: base_s = 24'd0;
      endcase
      outStep = base_s >> (7'd10 - octave_s);
   end

endmodule

// File: rtl/tableSinewave.sv
// 10-bit phase -> 12-bit signed sine, parabolic half-wave approximation.
module tableSinewave (
   input  logic [9:0]  inAddr,
   output logic [11:0] outSample
);

   logic [8:0]  x_s;
   logic [17:0] prod_s;
   logic [11:0] mag_s;

   // x*(511-x) peaks near 65280, so >>5 keeps the crest just under 2047.
   always_comb begin
      x_s    = inAddr[8:0];
      prod_s = 18'(x_s) * (18'd511 - 18'(x_s));
      mag_s  = 12'(prod_s >> 5);
      if (inAddr[9]) begin
         outSample = 12'd0 - mag_s;
      end else begin
         outSample = mag_s;
      end
   end

endmodule

// File: rtl/poly_sample_generator.sv
// Time-multiplexed polyphonic DDS: one voice per clock, mixed into one sample per strobe.
// Define POLY_SAMPLE_GEN_SATURATE_EN for a clamped full-amplitude mix with outClip.
module poly_sample_generator
   import poly_synth_pkg::*;
#(
   parameter int VOICES = 4,
   parameter int N      = 24,
   parameter int M      = 12
) (
   input  logic                  inCLK_50MHZ,
   input  logic                  inRST_N,
   input  logic                  inSAMPLE_CLK,
   input  logic [VOICES-1:0]     inVoiceGate,
   input  logic [2*VOICES-1:0]   inVoiceWaveMode,
   input  logic [7*VOICES-1:0]   inVoiceNote,
   output logic [M-1:0]          outSample,
   output logic                  outSampleReady,
   output logic                  outBusy,
   output logic                  outClip
);

   localparam int LOG2V = log2Ceil(VOICES);
   localparam int IW    = (LOG2V > 0) ? LOG2V : 1;
   localparam int SW    = M + LOG2V;

   fsmState_e              state_r;
   logic                   prevStrobe_r;
   logic [IW-1:0]          voiceIdx_r;
   logic [N-1:0]           phase_r [VOICES];
   logic                   st1Valid_r;
   logic [IW-1:0]          st1Voice_r;
   logic                   st1Gate_r;
   logic [1:0]             st1Mode_r;
   logic signed [SW-1:0]   sum_r;

   logic                   edge_s;
   logic                   gateSel_s;
   logic [1:0]             modeSel_s;
   logic [6:0]             noteSel_s;
   logic [N-1:0]           step_s;
   logic [11:0]            shapedWave_s;
   logic signed [M-1:0]    waveM_s;
   logic signed [SW-1:0]   waveExt_s;
   logic [M-1:0]           final_s;
   logic                   clip_s;

   // Stage-1 voice selection from the live inputs; nothing is latched per frame.
   always_comb begin
      edge_s    = inSAMPLE_CLK & ~prevStrobe_r;
      gateSel_s = inVoiceGate[voiceIdx_r];
      modeSel_s = inVoiceWaveMode[2*int'(voiceIdx_r) +: 2];
      noteSel_s = inVoiceNote[7*int'(voiceIdx_r) +: 7];
   end

   tableFrequencyStep stepTable (
      .inNote  (noteSel_s),
      .outStep (step_s)
   );

   poly_voice_shaper shaper (
      .inPhaseTop (phase_r[st1Voice_r][N-1:N-13]),
      .inMode     (st1Mode_r),
      .inGate     (st1Gate_r),
      .outWave    (shapedWave_s)
   );

   // Left-justify the 12-bit wave into M bits, then sign-extend to the accumulator.
   always_comb begin
      waveM_s   = M'($signed(shapedWave_s));
      waveM_s   = waveM_s <<< (M - 12);
      waveExt_s = SW'(waveM_s);
   end

`ifdef POLY_SAMPLE_GEN_SATURATE_EN
   localparam logic signed [SW-1:0] SAT_MAX = SW'((1 << (M - 1)) - 1);
   localparam logic signed [SW-1:0] SAT_MIN = SW'(-(1 << (M - 1)));

   // Clamp the full-amplitude mix into the output range.
   always_comb begin
      if (sum_r > SAT_MAX) begin
         final_s = M'(SAT_MAX);
         clip_s  = 1'b1;
      end else if (sum_r < SAT_MIN) begin
         final_s = M'(SAT_MIN);
         clip_s  = 1'b1;
      end else begin
         final_s = M'(sum_r);
         clip_s  = 1'b0;
      end
   end
`else
   // Scale by the voice count so the mix can never overflow.
   always_comb begin
      final_s = M'(sum_r >>> LOG2V);
      clip_s  = 1'b0;
   end
`endif

   // Phase accumulators: gate-off parks the phase at 0 so note-on restarts cleanly.
   always_ff @(posedge inCLK_50MHZ or negedge inRST_N) begin
      if (!inRST_N) begin
         for (int v = 0; v < VOICES; v++) begin
            phase_r[v] <= '0;
         end
      end else if (state_r == RUN) begin
         if (gateSel_s) begin
            phase_r[voiceIdx_r] <= phase_r[voiceIdx_r] + step_s;
         end else begin
            phase_r[voiceIdx_r] <= '0;
         end
      end else begin
         phase_r <= phase_r;
      end
   end

   // Frame FSM, stage-2 accumulation and registered outputs.
   always_ff @(posedge inCLK_50MHZ or negedge inRST_N) begin
      if (!inRST_N) begin
         state_r        <= IDLE;
         prevStrobe_r   <= 1'b0;
         voiceIdx_r     <= '0;
         st1Valid_r     <= 1'b0;
         st1Voice_r     <= '0;
         st1Gate_r      <= 1'b0;
         st1Mode_r      <= 2'd0;
         sum_r          <= '0;
         outSample      <= '0;
         outSampleReady <= 1'b0;
         outBusy        <= 1'b0;
         outClip        <= 1'b0;
      end else begin
         prevStrobe_r   <= inSAMPLE_CLK;
         outSampleReady <= 1'b0;
         outClip        <= 1'b0;
         st1Valid_r     <= (state_r == RUN);
         st1Voice_r     <= voiceIdx_r;
         st1Gate_r      <= gateSel_s;
         st1Mode_r      <= modeSel_s;
         if (st1Valid_r) begin
            sum_r <= sum_r + waveExt_s;
         end else begin
            sum_r <= sum_r;
         end
         case (state_r)
            IDLE: begin
               if (edge_s) begin
                  state_r    <= RUN;
                  voiceIdx_r <= '0;
                  sum_r      <= '0;
                  outBusy    <= 1'b1;
               end else begin
                  state_r <= IDLE;
               end
            end
            RUN: begin
               if (voiceIdx_r == IW'(VOICES - 1)) begin
                  state_r <= DRAIN;
               end else begin
                  voiceIdx_r <= voiceIdx_r + 1'b1;
               end
            end
            DRAIN: state_r <= DONE;
            DONE: begin
               outSample      <= final_s;
               outClip        <= clip_s;
               outSampleReady <= 1'b1;
               outBusy        <= 1'b0;
               state_r        <= IDLE;
            end
            default: state_r <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_poly_sample_generator.sv
// Scoreboard bench for poly_sample_generator (VOICES=4, N=24, M=12), both mix builds.
module tb_poly_sample_generator;

   logic        clk = 1'b0;
   logic        rstN = 1'b0;
   logic        sampleClk = 1'b0;
   logic [3:0]  gate = 4'd0;
   logic [7:0]  mode = 8'd0;
   logic [27:0] note = 28'd0;
   logic [11:0] outSample;
   logic        outSampleReady, outBusy, outClip;

   int total = 0;
   int bad = 0;
   int readyCount = 0;

   typedef struct {
      logic [11:0] sample;
      logic        clip;
   } exp_t;
   exp_t expQ[$];

   always #10 clk = ~clk;

   poly_sample_generator #(.VOICES(4), .N(24), .M(12)) dut (
      .inCLK_50MHZ     (clk),
      .inRST_N         (rstN),
      .inSAMPLE_CLK    (sampleClk),
      .inVoiceGate     (gate),
      .inVoiceWaveMode (mode),
      .inVoiceNote     (note),
      .outSample       (outSample),
      .outSampleReady  (outSampleReady),
      .outBusy         (outBusy),
      .outClip         (outClip)
   );

   // Final mix scaling for a hand-computed sum of 12-bit voice waves.
   function automatic exp_t mk(input int sum);
      exp_t e;
`ifdef POLY_SAMPLE_GEN_SATURATE_EN
      if (sum > 2047) begin
         e.sample = 12'h7ff; e.clip = 1'b1;
      end else if (sum < -2048) begin
         e.sample = 12'h800; e.clip = 1'b1;
      end else begin
         e.sample = 12'(sum); e.clip = 1'b0;
      end
`else
      e.sample = 12'(sum >>> 2);
      e.clip   = 1'b0;
`endif
      return e;
   endfunction

   // Saw = top 12 phase bits with the MSB inverted, as a signed value.
   function automatic int sawW(input int phase);
      int v;
      v = ((phase >> 12) & 32'hfff) ^ 32'h800;
      if (v >= 2048) v = v - 4096;
      return v;
   endfunction

   function automatic void check(input string name, input int got, input int req);
      total++;
      if (got != req) begin
         bad++;
         $display("FAIL %s: got %0d, required %0d", name, got, req);
      end
   endfunction

   // Monitor: pop and compare on every ready pulse.
   always @(negedge clk) begin
      exp_t e;
      if (rstN && outSampleReady) begin
         readyCount++;
         total++;
         if (expQ.size() == 0) begin
            bad++;
            $display("FAIL unexpected_ready: got sample=%h, required no output", outSample);
         end else begin
            e = expQ.pop_front();
            if (outSample !== e.sample || outClip !== e.clip) begin
               bad++;
               $display("FAIL sample: got %h clip=%b, required %h clip=%b",
                        outSample, outClip, e.sample, e.clip);
            end
         end
      end
   end

   task automatic frame(input logic [3:0] g, input logic [7:0] md, input logic [27:0] nt,
                        input int sum);
      @(negedge clk);
      gate = g; mode = md; note = nt;
      expQ.push_back(mk(sum));
      sampleClk = 1'b1;
      @(negedge clk);
      sampleClk = 1'b0;
      repeat (8) @(negedge clk);
   endtask

   localparam logic [27:0] N120_V0  = {21'd0, 7'd120};
   localparam logic [27:0] N120_V01 = {14'd0, 7'd120, 7'd120};
   localparam logic [27:0] N120_ALL = {7'd120, 7'd120, 7'd120, 7'd120};
   localparam logic [27:0] N0_ALL   = 28'd0;

   initial begin
      int first, pulses, busyCnt, rc0;
      // Reset held: strobe toggling must produce nothing.
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         sampleClk = ~sampleClk;
         check("reset_outputs", {outSample, outSampleReady, outBusy},
               {12'h000, 1'b0, 1'b0});
      end
      @(negedge clk);
      sampleClk = 1'b0;
      rstN = 1'b1;
      repeat (2) @(negedge clk);

      // Latency and busy window, all gates off.
      expQ.push_back(mk(0));
      sampleClk = 1'b1;
      @(posedge clk);
      #1;
      check("busy_after_t0", int'(outBusy), 1);
      first = 0; pulses = 0; busyCnt = 0;
      for (int k = 1; k <= 12; k++) begin
         @(posedge clk);
         #1;
         if (k == 1) sampleClk = 1'b0;
         if (outSampleReady) begin
            if (first == 0) first = k;
            pulses++;
            check("busy_low_at_ready", int'(outBusy), 0);
         end
         if (outBusy && first == 0) busyCnt++;
      end
      check("latency", first, 6);
      check("ready_pulses", pulses, 1);
      check("busy_cycles", busyCnt, 5);

      // Single voice square, note 120 (step 2926232): flips after 3 frames, wraps after 6.
      frame(4'b0001, 8'h01, N120_V0, 2047);
      frame(4'b0001, 8'h01, N120_V0, 2047);
      frame(4'b0001, 8'h01, N120_V0, -2047);
      frame(4'b0001, 8'h01, N120_V0, -2047);
      frame(4'b0001, 8'h01, N120_V0, -2047);
      frame(4'b0001, 8'h01, N120_V0, 2047);
      frame(4'b0000, 8'h01, N120_V0, 0);
      // Phase 0x2CA698 after one frame: saw 0xACA, triangle 0xD94, sine 1852.
      frame(4'b0001, 8'h02, N120_V0, -1334);
      frame(4'b0000, 8'h02, N120_V0, 0);
      frame(4'b0001, 8'h03, N120_V0, -620);
      frame(4'b0000, 8'h03, N120_V0, 0);
      frame(4'b0001, 8'h00, N120_V0, 1852);
      frame(4'b0000, 8'h00, N120_V0, 0);
      // Two voices mixed: saw on voice 0 plus triangle on voice 1.
      frame(4'b0011, 8'h0E, N120_V01, -1954);
      frame(4'b0000, 8'h0E, N120_V01, 0);
      // Four identical squares: saturates (or scales back) at both polarities.
      frame(4'b1111, 8'h55, N120_ALL, 8188);
      frame(4'b1111, 8'h55, N120_ALL, 8188);
      frame(4'b1111, 8'h55, N120_ALL, -8188);
      frame(4'b0000, 8'h55, N120_ALL, 0);

      // Retrigger: note 0 has step 2857; after gate-off the phase restarts at step.
      for (int k = 1; k <= 100; k++) begin
         frame(4'b0001, 8'h02, N0_ALL, sawW(k * 2857));
      end
      frame(4'b0000, 8'h02, N0_ALL, 0);
      frame(4'b0001, 8'h02, N0_ALL, -2048);
      frame(4'b0000, 8'h02, N0_ALL, 0);

      // Overrun: second edge 3 clocks after the first is ignored.
      rc0 = readyCount;
      @(negedge clk);
      gate = 4'b0001; mode = 8'h02; note = N120_V0;
      expQ.push_back(mk(-1334));
      sampleClk = 1'b1;
      @(negedge clk); sampleClk = 1'b0;
      @(negedge clk);
      @(negedge clk); sampleClk = 1'b1;
      @(negedge clk); sampleClk = 1'b0;
      repeat (12) @(negedge clk);
      check("overrun_ready_count", readyCount - rc0, 1);

      // Reset mid-frame: no output, phases cleared.
      rc0 = readyCount;
      @(negedge clk);
      sampleClk = 1'b1;
      @(negedge clk); sampleClk = 1'b0;
      @(negedge clk);
      @(negedge clk); rstN = 1'b0;
      repeat (2) @(negedge clk);
      rstN = 1'b1;
      repeat (12) @(negedge clk);
      check("abort_ready_count", readyCount - rc0, 0);
      frame(4'b0001, 8'h02, N120_V0, -1334);

      repeat (4) @(negedge clk);
      check("queue_drained", expQ.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got no completion, required finish before 1 ms");
      $fatal(1);
   end

endmodule
